booth8_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16x16 radix-8 Booth/Wallace multiplier.
- Generalised to WIDTH-bit operands, with a per-transaction signed/unsigned mode and a transaction tag.
- Three register stages (recode/partial products, carry-save compression, final carry-propagate add) under a valid/ready handshake with full-pipeline stall.
- Sits between operand-issue logic and result consumers in the datapath.

---
 rtl/booth8_mult_pipe.sv | 197 +++++++++++++++++++
 tb/tb_booth8_mult_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth8_mult_pipe.sv
// booth8_mult_pipe: 3-stage radix-8 Booth / Wallace multiplier with a
// per-op signed mode, tag sideband and whole-pipeline stall.
module booth8_mult_pipe #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int EW  = WIDTH + 2;
   localparam int G   = (EW + 2) / 3;
   localparam int PPW = WIDTH + 5;
   localparam int PW  = 2 * WIDTH;
   localparam int NR  = G + 1;
   localparam int MPW = 3 * G + 1;

   logic             stall;
   logic             adv;
   logic             take;

   logic [PPW-1:0]   pp_d [G];
   logic [G-1:0]     neg_d;

   logic [PPW-1:0]   s1_pp_q [G];
   logic [G-1:0]     s1_neg_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic             s1_vld_q;

   logic [PW-1:0]    s2_sum_d;
   logic [PW-1:0]    s2_cry_d;
   logic [PW-1:0]    s2_sum_q;
   logic [PW-1:0]    s2_cry_q;
   logic [TAG_W-1:0] s2_tag_q;
   logic             s2_vld_q;

   logic [PW-1:0]    prod_d;
   logic [PW-1:0]    prod_q;
   logic [TAG_W-1:0] tag3_q;
   logic             vld3_q;

   assign stall    = vld3_q & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = adv;
   assign take     = in_valid & adv;

   always_comb begin
      logic [EW-1:0]    mc_e;
      logic [EW-1:0]    mp_e;
      logic [MPW-1:0]   mp_pad;
      logic [PPW-1:0]   m1;
      logic [PPW-1:0]   m2;
      logic [PPW-1:0]   m3;
      logic [PPW-1:0]   m4;
      logic [3:0]       grp;
      logic [PPW-1:0]   mag;
      logic             neg;
      mc_e   = {{2{in_signed & mcand[WIDTH-1]}}, mcand};
      mp_e   = {{2{in_signed & mplier[WIDTH-1]}}, mplier};
      mp_pad = {(MPW-1)'($signed(mp_e)), 1'b0};
      m1     = PPW'($signed(mc_e));
      m2     = m1 << 1;
      m3     = m1 + m2;
      m4     = m1 << 2;
      neg_d  = '0;
      grp    = '0;
      mag    = '0;
      neg    = 1'b0;
      for (int g = 0; g < G; g++) begin
         grp = mp_pad[3*g +: 4];
         case (grp)
            4'b0001, 4'b0010,
            4'b1101, 4'b1110: mag = m1;
            4'b0011, 4'b0100,
            4'b1011, 4'b1100: mag = m2;
            4'b0101, 4'b0110,
            4'b1001, 4'b1010: mag = m3;
            4'b0111, 4'b1000: mag = m4;
            default:          mag = '0;
         endcase
         // 1111 is digit zero, so it must not request a +1 correction
         neg      = grp[3] & ~(grp[2] & grp[1] & grp[0]);
         pp_d[g]  = neg ? ~mag : mag;
         neg_d[g] = neg;
      end
   end

   always_comb begin
      logic [PW-1:0] r [NR];
      logic [PW-1:0] t [NR];
      logic [PW-1:0] a;
      logic [PW-1:0] b;
      logic [PW-1:0] c;
      int            cnt;
      int            nc;
      int            full;
      a    = '0;
      b    = '0;
      c    = '0;
      nc   = 0;
      full = 0;
      for (int i = 0; i < NR; i++) begin
         r[i] = '0;
         t[i] = '0;
      end
      for (int g = 0; g < G; g++) begin
         r[g] = PW'($signed(s1_pp_q[g])) << (3 * g);
         r[G][3*g] = s1_neg_q[g];
      end
      cnt = NR;
      for (int l = 0; l < NR; l++) begin
         if (cnt > 2) begin
            for (int i = 0; i < NR; i++) begin
               t[i] = '0;
            end
            nc   = 0;
            full = (cnt / 3) * 3;
            for (int i = 0; i + 2 < NR; i += 3) begin
               if (i + 2 < cnt) begin
                  a       = r[i];
                  b       = r[i+1];
                  c       = r[i+2];
                  t[nc]   = a ^ b ^ c;
                  t[nc+1] = ((a & b) | (a & c) | (b & c)) << 1;
                  nc      = nc + 2;
               end
            end
            for (int i = 0; i < NR; i++) begin
               if (i >= full && i < cnt) begin
                  t[nc] = r[i];
                  nc    = nc + 1;
               end
            end
            cnt = nc;
            for (int i = 0; i < NR; i++) begin
               r[i] = t[i];
            end
         end
      end
      s2_sum_d = r[0];
      s2_cry_d = r[1];
   end

   assign prod_d = s2_sum_q + s2_cry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < G; g++) begin
            s1_pp_q[g] <= '0;
         end
         s1_neg_q <= '0;
         s1_tag_q <= '0;
         s1_vld_q <= 1'b0;
         s2_sum_q <= '0;
         s2_cry_q <= '0;
         s2_tag_q <= '0;
         s2_vld_q <= 1'b0;
         prod_q   <= '0;
         tag3_q   <= '0;
         vld3_q   <= 1'b0;
      end else if (adv) begin
         s1_vld_q <= take;
         if (take) begin
            for (int g = 0; g < G; g++) begin
               s1_pp_q[g] <= pp_d[g];
            end
            s1_neg_q <= neg_d;
            s1_tag_q <= in_tag;
         end
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_sum_q <= s2_sum_d;
            s2_cry_q <= s2_cry_d;
            s2_tag_q <= s1_tag_q;
         end
         vld3_q <= s2_vld_q;
         if (s2_vld_q) begin
            prod_q <= prod_d;
            tag3_q <= s2_tag_q;
         end
      end
   end

   assign out_valid = vld3_q;
   assign product   = prod_q;
   assign out_tag   = tag3_q;

endmodule

// File: tb/tb_booth8_mult_pipe.sv
// tb_booth8_mult_pipe: scoreboard bench for booth8_mult_pipe at WIDTH=16,
// directed vectors with latency, stall, reset and recoding corner cases.
module tb_booth8_mult_pipe;
   localparam int W  = 16;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_signed = 1'b0;
   logic [W-1:0]  mcand = '0;
   logic [W-1:0]  mplier = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [2*W-1:0] product;
   logic [TW-1:0] out_tag;

   typedef struct packed {
      logic [2*W-1:0] p;
      logic [TW-1:0]  t;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_pop = 0;
   int   cyc = 0;
   int   pop_cyc = 0;
   int   prev_pop_cyc = 0;
   bit   done = 1'b0;

   booth8_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .mcand(mcand),
      .mplier(mplier), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .out_tag(out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(logic s, logic [15:0] a,
                                         logic [15:0] b);
      logic signed [16:0] ea;
      logic signed [16:0] eb;
      logic signed [33:0] p;
      ea = $signed({s & a[15], a});
      eb = $signed({s & b[15], b});
      p  = ea * eb;
      return p[31:0];
   endfunction

   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: product 0x%0h tag %0d",
                     product, out_tag);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("product", product, e.p);
            chk("out_tag", out_tag, e.t);
         end
         n_pop++;
         prev_pop_cyc = pop_cyc;
         pop_cyc = cyc;
      end
   end

   task automatic send(logic s, logic [W-1:0] a, logic [W-1:0] b,
                       logic [TW-1:0] t, logic [2*W-1:0] e);
      exp_t x;
      bit   ok;
      ok = 1'b0;
      in_valid  = 1'b1;
      in_signed = s;
      mcand     = a;
      mplier    = b;
      in_tag    = t;
      for (int k = 0; k < 200 && !ok; k++) begin
         #1;
         ok = in_ready;
         @(posedge clk);
         if (ok) begin
            x.p = e;
            x.t = t;
            q.push_back(x);
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: tag %0d never accepted", t);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results missing", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] mpl [8];
      logic [15:0] mca [5];
      int          n0;
      int          tg;
      mpl = '{16'h0000, 16'h0001, 16'h0003, 16'h0004,
              16'h7FFF, 16'h8000, 16'hAAAA, 16'h5555};
      mca = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_product", product, 0);
      chk("rst_out_tag", out_tag, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(1'b1, 16'h8000, 16'h8000, 4'd0, 32'h40000000);
      #1 chk("lat_cycle1", out_valid, 0);
      @(negedge clk);
      #1 chk("lat_cycle2", out_valid, 0);
      @(negedge clk);
      #1 chk("lat_cycle3", out_valid, 1);
      @(negedge clk);
      send(1'b1, 16'hFFFF, 16'h0003, 4'd3, 32'hFFFFFFFD);
      drain();

      send(1'b0, 16'hFFFF, 16'hFFFF, 4'd1, 32'hFFFE0001);
      send(1'b1, 16'hFFFF, 16'hFFFF, 4'd2, 32'h00000001);
      drain();
      chk("b2b_consecutive", pop_cyc - prev_pop_cyc, 1);

      n0 = n_pop;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(1'b0, W'(i + 2), W'(i + 3), TW'(i),
                    32'((i + 2) * (i + 3)));
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
               @(negedge clk);
               seen = out_valid;
            end
            if (!seen) begin
               n_chk++;
               n_fail++;
               $display("FAIL bp_no_output: out_valid never rose");
            end
            out_ready = 1'b0;
            repeat (4) begin
               #1;
               chk("bp_in_ready", in_ready, 0);
               chk("bp_product_hold", product, 6);
               chk("bp_tag_hold", out_tag, 0);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_delivered", n_pop - n0, 5);

      out_ready = 1'b0;
      send(1'b0, 16'd100, 16'd7, 4'd5, 32'd700);
      send(1'b1, 16'hFFFE, 16'd9, 4'd6, 32'hFFFFFFEE);
      send(1'b0, 16'd300, 16'd300, 4'd7, 32'd90000);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_product", product, 0);
      chk("arst_out_tag", out_tag, 0);
      chk("arst_in_ready", in_ready, 1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      n0 = n_pop;
      repeat (6) begin
         @(negedge clk);
         #1 chk("post_rst_idle", out_valid, 0);
      end
      chk("post_rst_pops", n_pop - n0, 0);
      @(negedge clk);

      tg = 0;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 5; j++) begin
               send(s[0], mca[j], mpl[i], TW'(tg),
                    model(s[0], mca[j], mpl[i]));
               tg++;
            end
      drain();

      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               logic [15:0] a;
               logic [15:0] b;
               logic        s;
               a = 16'($urandom);
               b = 16'($urandom);
               s = 1'($urandom_range(0, 1));
               send(s, a, b, TW'(i), model(s, a, b));
               if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
